// File: rtl/stage_sequencer.sv
// stage_sequencer: one-hot N-stage sequencer with per-stage dwell, one-shot/loop, abort; STAGE_SEQ_DIR_EN adds a descending-direction option
module stage_sequencer #(
   parameter int NUM_STAGES = 6,
   parameter int DWELL_W    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          shift,
   input  logic                          mode,
   input  logic [DWELL_W-1:0]            dwell,
   input  logic                          abort,
`ifdef STAGE_SEQ_DIR_EN
   input  logic                          dir,
`endif
   output logic [NUM_STAGES-1:0]         out,
   output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
   output logic                          busy,
   output logic                          done
);
   localparam int IW = $clog2(NUM_STAGES);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   localparam logic [NUM_STAGES-1:0] FIRST_UP = NUM_STAGES'(1);
   localparam logic [NUM_STAGES-1:0] FIRST_DN = FIRST_UP << (NUM_STAGES - 1);
   localparam logic [IW-1:0] TOP = IW'(NUM_STAGES - 1);

   logic               dir_in;
   logic [0:0]         state;
   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] dwell_q;
   logic               mode_q;
   logic               dir_q;
   logic               last;

`ifdef STAGE_SEQ_DIR_EN
   assign dir_in = dir;
`else
   assign dir_in = 1'b0;
`endif

   assign last = dir_q ? (stage_idx == '0) : (stage_idx == TOP);
   assign busy = (state == RUN);

   // sequencing state: abort wins, IDLE waits for start, RUN advances on shift-qualified dwell expiry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         out       <= '0;
         stage_idx <= '0;
         done      <= 1'b0;
         cnt       <= '0;
         dwell_q   <= '0;
         mode_q    <= 1'b0;
         dir_q     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            out       <= '0;
            stage_idx <= '0;
            cnt       <= '0;
         end else if (state == IDLE) begin
            if (start) begin
               state     <= RUN;
               out       <= dir_in ? FIRST_DN : FIRST_UP;
               stage_idx <= dir_in ? TOP : '0;
               cnt       <= '0;
               dwell_q   <= dwell;
               mode_q    <= mode;
               dir_q     <= dir_in;
            end
         end else if (shift) begin
            if (cnt == dwell_q) begin
               cnt <= '0;
               if (last) begin
                  done <= 1'b1;
                  if (mode_q) begin
                     out       <= dir_q ? FIRST_DN : FIRST_UP;
                     stage_idx <= dir_q ? TOP : '0;
                  end else begin
                     state     <= IDLE;
                     out       <= '0;
                     stage_idx <= '0;
                  end
               end else begin
                  out       <= dir_q ? out >> 1 : out << 1;
                  stage_idx <= dir_q ? stage_idx - IW'(1) : stage_idx + IW'(1);
               end
            end else begin
               cnt <= cnt + DWELL_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed bench for stage_sequencer (default build, ascending only)
module tb_stage_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       shift = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] dwell = 4'd0;
   logic       abort = 1'b0;
   logic [5:0] out;
   logic [2:0] stage_idx;
   logic       busy;
   logic       done;
   logic [10:0] obs;
   int checks = 0;
   int errors = 0;

   assign obs = {out, stage_idx, busy, done};

   stage_sequencer #(.NUM_STAGES(6), .DWELL_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .shift(shift), .mode(mode),
      .dwell(dwell), .abort(abort), .out(out), .stage_idx(stage_idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (obs !== 11'b000000_000_0_0) begin
         errors++;
         $display("FAIL reset_state got=%b want=%b", obs, 11'b000000_000_0_0);
      end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_one_shot();
      logic [10:0] exp;
      start = 1'b1; mode = 1'b0; dwell = 4'd0; shift = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp = {6'b000001 << i, 3'(i), 1'b1, 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL one_shot_stage%0d got=%b want=%b", i, obs, exp);
         end
         tick();
      end
      checks++;
      if (obs !== 11'b000000_000_0_1) begin
         errors++;
         $display("FAIL one_shot_done got=%b want=%b", obs, 11'b000000_000_0_1);
      end
      tick();
      checks++;
      if (obs !== 11'b000000_000_0_0) begin
         errors++;
         $display("FAIL one_shot_done_clear got=%b want=%b", obs, 11'b000000_000_0_0);
      end
   endtask

   task automatic test_back_to_back();
      start = 1'b1; mode = 1'b0; dwell = 4'd0; shift = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      checks++;
      if (obs !== 11'b000000_000_0_1) begin
         errors++;
         $display("FAIL b2b_done got=%b want=%b", obs, 11'b000000_000_0_1);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (obs !== 11'b000001_000_1_0) begin
         errors++;
         $display("FAIL b2b_restart got=%b want=%b", obs, 11'b000001_000_1_0);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_dwell_freeze();
      logic       pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [5:0] want [4] = '{6'b000001, 6'b000001, 6'b000001, 6'b000010};
      start = 1'b1; mode = 1'b0; dwell = 4'd2; shift = 1'b1;
      tick();
      start = 1'b0;
      dwell = 4'd0;
      for (int i = 0; i < 4; i++) begin
         shift = pat[i];
         tick();
         checks++;
         if (out !== want[i]) begin
            errors++;
            $display("FAIL dwell_step%0d out=%b want=%b", i, out, want[i]);
         end
      end
      abort = 1'b1; shift = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b1; dwell = 4'd15;
      tick();
      start = 1'b0;
      repeat (15) tick();
      checks++;
      if (obs !== 11'b000001_000_1_0) begin
         errors++;
         $display("FAIL dwell_max_hold got=%b want=%b", obs, 11'b000001_000_1_0);
      end
      tick();
      checks++;
      if (obs !== 11'b000010_001_1_0) begin
         errors++;
         $display("FAIL dwell_max_adv got=%b want=%b", obs, 11'b000010_001_1_0);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_loop();
      logic [10:0] exp;
      start = 1'b1; mode = 1'b1; dwell = 4'd1; shift = 1'b1;
      tick();
      start = 1'b0;
      mode = 1'b0;
      for (int t = 1; t <= 25; t++) begin
         if (t == 5) start = 1'b1;
         tick();
         start = 1'b0;
         exp = {6'b000001 << ((t % 12) / 2), 3'((t % 12) / 2), 1'b1, (t % 12) == 0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL loop_t%0d got=%b want=%b", t, obs, exp);
         end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_abort();
      start = 1'b1; mode = 1'b0; dwell = 4'd0; shift = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      checks++;
      if (obs !== 11'b000100_010_1_0) begin
         errors++;
         $display("FAIL abort_pre got=%b want=%b", obs, 11'b000100_010_1_0);
      end
      abort = 1'b1;
      tick();
      checks++;
      if (obs !== 11'b000000_000_0_0) begin
         errors++;
         $display("FAIL abort_idle got=%b want=%b", obs, 11'b000000_000_0_0);
      end
      start = 1'b1;
      tick();
      checks++;
      if (obs !== 11'b000000_000_0_0) begin
         errors++;
         $display("FAIL start_abort_idle got=%b want=%b", obs, 11'b000000_000_0_0);
      end
      start = 1'b0; abort = 1'b0;
      tick();
   endtask

   task automatic test_reset_midrun();
      start = 1'b1; mode = 1'b0; dwell = 4'd0; shift = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      checks++;
      if (obs !== 11'b001000_011_1_0) begin
         errors++;
         $display("FAIL midrun_stage3 got=%b want=%b", obs, 11'b001000_011_1_0);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs !== 11'b000000_000_0_0) begin
         errors++;
         $display("FAIL async_reset got=%b want=%b", obs, 11'b000000_000_0_0);
      end
      start = 1'b1;
      tick();
      rst = 1'b1;
      checks++;
      if (obs !== 11'b000000_000_0_0) begin
         errors++;
         $display("FAIL reset_held got=%b want=%b", obs, 11'b000000_000_0_0);
      end
      tick();
      start = 1'b0;
      checks++;
      if (obs !== 11'b000001_000_1_0) begin
         errors++;
         $display("FAIL reset_restart got=%b want=%b", obs, 11'b000001_000_1_0);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_back_to_back();
      test_dwell_freeze();
      test_loop();
      test_abort();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
